// File: rtl/iecdrv_pkg.sv
// Shared types for the multi-drive IEC subsystem.
// Holds the SD arbiter state encoding and subsystem-wide limits.
package iecdrv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_XFER,
        ARB_RELEASE
    } arb_state_t;

    localparam int MAX_DRIVES = 4;
    localparam int CNT_W      = 24;

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Combinational round-robin picker: first requester after the last grant,
// scanning last+1 .. last+NDR modulo NDR.
module iecdrv_rr_pick
    import iecdrv_pkg::*;
#(
    parameter int NDR = 2
) (
    input  logic [NDR-1:0]                  i_req,
    input  logic [1:0]                      i_last,
    output logic                            o_valid,
    output logic [$clog2(MAX_DRIVES)-1:0]   o_idx
);

    // Scan from the farthest candidate back so the nearest one wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NDR; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NDR]) begin
                o_valid = 1'b1;
                o_idx   = 2'((int'(i_last) + k) % NDR);
            end
        end
    end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Shares the single host SD block port among NDR drives, round-robin,
// holding each grant until the host transfer has completed.
module iecdrv_sd_arbiter
    import iecdrv_pkg::*;
#(
    parameter int               NDR     = 2,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NDR-1:0][31:0]    drv_lba,
    input  logic [NDR-1:0][5:0]     drv_blk_cnt,
    input  logic [NDR-1:0]          drv_rd,
    input  logic [NDR-1:0]          drv_wr,
    input  logic [NDR-1:0][7:0]     drv_buff_din,
    output logic [NDR-1:0]          drv_ack,
    output logic [31:0]             host_lba,
    output logic [5:0]              host_blk_cnt,
    output logic                    host_rd,
    output logic                    host_wr,
    input  logic                    host_ack,
    output logic [7:0]              host_buff_din,
    output logic [1:0]              grant_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam int         IW       = (NDR > 1) ? $clog2(NDR) : 1;
    localparam logic [1:0] LAST_RST = 2'(NDR - 1);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [1:0]         r_grant;
    logic [1:0]         r_last;
    logic [1:0]         w_pick_idx;
    logic               w_pick_valid;
    logic [IW-1:0]      w_gidx;
    logic [IW-1:0]      w_pidx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [31:0]        r_lba;
    logic [5:0]         r_blk;
    logic               r_rd;
    logic               r_wr;
    logic               r_tmo;
    logic [NDR-1:0]     w_req;
    logic               w_greq;
    logic               w_granted;
    logic               w_tmo_hit;
    logic               w_take;
    logic               w_clr;
    logic               w_abort;

    assign w_req     = drv_rd | drv_wr;
    assign w_gidx    = r_grant[IW-1:0];
    assign w_pidx    = w_pick_idx[IW-1:0];
    assign w_greq    = w_req[w_gidx];
    assign w_granted = (r_state == ARB_ISSUE) || (r_state == ARB_XFER);

    // Saturating so a disabled timeout never wraps into a false abort.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_tmo_hit = (TIMEOUT != '0) && (w_cnt_inc == TIMEOUT);

    iecdrv_rr_pick #(
        .NDR     (NDR)
    ) u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_take  = 1'b0;
        w_clr   = 1'b0;
        w_abort = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_next = ARB_ISSUE;
                    w_take = 1'b1;
                end
            end
            ARB_ISSUE: begin
                if (host_ack) begin
                    w_next = ARB_XFER;
                    w_clr  = 1'b1;
                end else if (!w_greq) begin
                    w_next = ARB_RELEASE;
                    w_clr  = 1'b1;
                end else if (w_tmo_hit) begin
                    w_next  = ARB_RELEASE;
                    w_clr   = 1'b1;
                    w_abort = 1'b1;
                end
            end
            ARB_XFER: begin
                if (!host_ack) begin
                    w_next = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                w_next = ARB_IDLE;
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
            r_lba   <= '0;
            r_blk   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_tmo <= w_abort;
            if (w_take) begin
                r_grant <= w_pick_idx;
                r_last  <= w_pick_idx;
                r_cnt   <= '0;
                r_lba   <= drv_lba[w_pidx];
                r_blk   <= drv_blk_cnt[w_pidx];
                r_wr    <= drv_wr[w_pidx];
                r_rd    <= drv_rd[w_pidx] & ~drv_wr[w_pidx];
            end else begin
                if (r_state == ARB_ISSUE) begin
                    r_cnt <= w_cnt_inc;
                end
                if (w_clr) begin
                    r_rd <= 1'b0;
                    r_wr <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        drv_ack       = '0;
        host_buff_din = 8'h00;
        if (w_granted) begin
            drv_ack[w_gidx] = host_ack;
            host_buff_din   = drv_buff_din[w_gidx];
        end
    end

    assign host_lba     = r_lba;
    assign host_blk_cnt = r_blk;
    assign host_rd      = r_rd;
    assign host_wr      = r_wr;
    assign grant_id     = r_grant;
    assign busy         = (r_state != ARB_IDLE);
    assign timeout      = r_tmo;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Bench for iecdrv_sd_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level ownership model.
module tb_iecdrv_sd_arbiter;

    localparam int          NDR = 2;
    localparam logic [23:0] TMO = 24'd16;

    logic                   clk_sys = 1'b0;
    logic                   reset;
    logic [NDR-1:0][31:0]   drv_lba;
    logic [NDR-1:0][5:0]    drv_blk_cnt;
    logic [NDR-1:0]         drv_rd;
    logic [NDR-1:0]         drv_wr;
    logic [NDR-1:0][7:0]    drv_buff_din;
    logic [NDR-1:0]         drv_ack;
    logic [31:0]            host_lba;
    logic [5:0]             host_blk_cnt;
    logic                   host_rd;
    logic                   host_wr;
    logic                   host_ack;
    logic [7:0]             host_buff_din;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   timeout;

    iecdrv_sd_arbiter #(
        .NDR           (NDR),
        .TIMEOUT       (TMO)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .drv_lba       (drv_lba),
        .drv_blk_cnt   (drv_blk_cnt),
        .drv_rd        (drv_rd),
        .drv_wr        (drv_wr),
        .drv_buff_din  (drv_buff_din),
        .drv_ack       (drv_ack),
        .host_lba      (host_lba),
        .host_blk_cnt  (host_blk_cnt),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: who owns the host port, whether the host has answered,
    // how many issue cycles have elapsed, and a one-cycle cooldown.
    int          m_owner;
    int          m_last;
    int          m_wait;
    int          m_gid;
    bit          m_acked;
    bit          m_cool;
    bit          m_rd;
    bit          m_wr;
    bit          m_tmo;
    logic [31:0] m_lba;
    logic [5:0]  m_blk;

    function automatic void m_drop();
        m_owner = -1;
        m_cool  = 1'b1;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
    endfunction

    function automatic void m_step();
        m_tmo = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_cool  = 1'b0;
            m_last  = NDR - 1;
            m_gid   = 0;
            m_rd    = 1'b0;
            m_wr    = 1'b0;
            m_lba   = '0;
            m_blk   = '0;
            m_acked = 1'b0;
            m_wait  = 0;
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NDR; k++) begin
                int i;
                i = (m_last + k) % NDR;
                if (m_owner < 0 && (drv_rd[i] || drv_wr[i])) begin
                    m_owner = i;
                    m_last  = i;
                    m_gid   = i;
                    m_lba   = drv_lba[i];
                    m_blk   = drv_blk_cnt[i];
                    m_wr    = drv_wr[i];
                    m_rd    = drv_rd[i] && !drv_wr[i];
                    m_acked = 1'b0;
                    m_wait  = 0;
                end
            end
        end else if (!m_acked) begin
            m_wait++;
            if (host_ack) begin
                m_acked = 1'b1;
                m_rd    = 1'b0;
                m_wr    = 1'b0;
            end else if (!(drv_rd[m_owner] || drv_wr[m_owner])) begin
                m_drop();
            end else if (TMO != 0 && m_wait == int'(TMO)) begin
                m_drop();
                m_tmo = 1'b1;
            end
        end else if (!host_ack) begin
            m_drop();
        end
    endfunction

    task automatic check_all();
        logic [NDR-1:0] e_ack;
        logic [7:0]     e_din;
        e_ack = '0;
        e_din = 8'h00;
        if (m_owner >= 0) begin
            e_ack[m_owner] = host_ack;
            e_din          = drv_buff_din[m_owner];
        end
        chk("m_host_rd", host_rd, m_rd);
        chk("m_host_wr", host_wr, m_wr);
        chk("m_drv_ack", drv_ack, e_ack);
        chk("m_busy", busy, (m_owner >= 0) || m_cool);
        chk("m_grant_id", grant_id, m_gid);
        chk("m_host_lba", host_lba, m_lba);
        chk("m_host_blk", host_blk_cnt, m_blk);
        chk("m_timeout", timeout, m_tmo);
        chk("m_buff_din", host_buff_din, e_din);
    endtask

    task automatic mid();
        @(negedge clk_sys);
        check_all();
    endtask

    task automatic edge_();
        @(posedge clk_sys);
        m_step();
        #1;
    endtask

    task automatic tick();
        mid();
        edge_();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        drv_rd   = '0;
        drv_wr   = '0;
        host_ack = 1'b0;
    endtask

    typedef struct {
        logic [1:0] rd;
        logic [1:0] wr;
        logic       ack;
        logic       e_rd;
        logic       e_wr;
        logic [1:0] e_dack;
        int         e_busy;
    } vec_t;

    vec_t vt[$];

    initial begin
        reset        = 1'b1;
        drv_rd       = '0;
        drv_wr       = '0;
        host_ack     = 1'b0;
        drv_lba      = {32'hB000_0001, 32'hA000_0000};
        drv_blk_cnt  = {6'd9, 6'd3};
        drv_buff_din = {8'h5A, 8'hC3};

        edge_();
        mid();
        chk("rst_host_rd", host_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_drv_ack", drv_ack, 2'b00);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_lba", host_lba, 32'h0);
        edge_();
        reset = 1'b0;

        // Single read: busy value 2 marks a row where busy is not compared.
        vt.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 0});
        vt.push_back('{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1});
        vt.push_back('{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1});
        vt.push_back('{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1});
        for (int i = 0; i < 7; i++)
            vt.push_back('{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1});
        vt.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1});
        vt.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2});
        vt.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 0});

        foreach (vt[i]) begin
            drv_rd   = vt[i].rd;
            drv_wr   = vt[i].wr;
            host_ack = vt[i].ack;
            mid();
            chk($sformatf("v%0d_host_rd", i), host_rd, vt[i].e_rd);
            chk($sformatf("v%0d_host_wr", i), host_wr, vt[i].e_wr);
            chk($sformatf("v%0d_drv_ack", i), drv_ack, vt[i].e_dack);
            if (vt[i].e_busy != 2)
                chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy[0]);
            edge_();
        end

        // Both drives read continuously: grants alternate from drive 0.
        do_reset();
        drv_rd = 2'b11;
        for (int g = 0; g < 4; g++) begin
            int          n;
            logic [31:0] exp_lba;
            n = 0;
            exp_lba = drv_lba[g % 2];
            while (!host_rd && n < 20) begin
                tick();
                n++;
            end
            chk("rr_wait", (n < 20), 1'b1);
            chk("rr_grant", grant_id, 2'(g % 2));
            chk("rr_lba", host_lba, exp_lba);
            drv_lba[g % 2] = drv_lba[g % 2] ^ 32'h0000_FFFF;
            mid();
            chk("rr_lba_latched", host_lba, exp_lba);
            edge_();
            host_ack = 1'b1;
            tick();
            host_ack = 1'b0;
            tick();
        end

        // Read and write together on drive 1: write wins.
        do_reset();
        drv_rd = 2'b10;
        drv_wr = 2'b10;
        tick();
        mid();
        chk("rw_host_wr", host_wr, 1'b1);
        chk("rw_host_rd", host_rd, 1'b0);
        chk("rw_grant", grant_id, 2'd1);
        edge_();
        host_ack = 1'b1;
        drv_rd   = '0;
        drv_wr   = '0;
        tick();
        host_ack = 1'b0;
        tick();
        tick();

        // Timeout with both requesting: abort, then the other drive.
        do_reset();
        drv_rd = 2'b11;
        for (int t = 0; t < 20; t++) begin
            mid();
            if (t == 16) chk("tmo_early", timeout, 1'b0);
            if (t == 17) chk("tmo_pulse", timeout, 1'b1);
            if (t == 18) chk("tmo_once", timeout, 1'b0);
            if (t == 19) chk("tmo_next_grant", grant_id, 2'd1);
            edge_();
        end

        // Reset in the middle of a transfer.
        do_reset();
        drv_rd = 2'b10;
        tick();
        host_ack = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mid();
        chk("rx_host_rd", host_rd, 1'b0);
        chk("rx_drv_ack", drv_ack, 2'b00);
        chk("rx_grant", grant_id, 2'd0);
        chk("rx_busy", busy, 1'b0);
        edge_();
        drv_rd   = '0;
        host_ack = 1'b0;
        tick();

        // Withdraw during issue; a late host ack is ignored.
        do_reset();
        drv_rd = 2'b01;
        tick();
        tick();
        drv_rd = 2'b00;
        mid();
        chk("wd_no_ack", drv_ack, 2'b00);
        edge_();
        host_ack = 1'b1;
        mid();
        chk("wd_rel_ack", drv_ack, 2'b00);
        chk("wd_rel_busy", busy, 1'b1);
        chk("wd_rel_rd", host_rd, 1'b0);
        edge_();
        mid();
        chk("wd_idle_ack", drv_ack, 2'b00);
        chk("wd_idle_busy", busy, 1'b0);
        edge_();
        host_ack = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NDR; i++) begin
                if ($urandom_range(0, 7) == 0) drv_rd[i] = ~drv_rd[i];
                if ($urandom_range(0, 11) == 0) drv_wr[i] = ~drv_wr[i];
                drv_lba[i]      = $urandom;
                drv_blk_cnt[i]  = 6'($urandom);
                drv_buff_din[i] = 8'($urandom);
            end
            host_ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
